// File: rtl/mp_pkg.sv
// Shared definitions for the multi-precision datapath blocks.
// Holds default operand sizes, the sequencer state encoding and a ceil-div helper.
package mp_pkg;

    localparam int MP_WIDTH = 514;
    localparam int MP_LIMB  = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mp_state_e;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

endpackage

// File: rtl/mp_limb_adder.sv
// One limb slice of the multi-precision adder.
// Computes a + b + cin and returns the limb sum with its carry-out.
module mp_limb_adder #(
    parameter int LIMB = 128
) (
    input  logic [LIMB-1:0] a_i,
    input  logic [LIMB-1:0] b_i,
    input  logic            cin_i,
    output logic [LIMB-1:0] sum_o,
    output logic            cout_o
);

    // Full-width add with one extra bit to capture the carry-out.
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{LIMB{1'b0}}, cin_i};

endmodule

// File: rtl/mp_addsub_seq.sv
// Sequential WIDTH-bit add/subtract engine, one LIMB-bit limb per clock.
// Operands are zero-padded to NLIMB*LIMB bits; the flag comes from bit WIDTH of the padded sum.
module mp_addsub_seq
    import mp_pkg::*;
#(
    parameter int WIDTH = MP_WIDTH,
    parameter int LIMB  = MP_LIMB
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH:0]   C,
    output logic             done,
    output logic             busy
);

    localparam int NLIMB = ceil_div(WIDTH, LIMB);
    localparam int PW    = NLIMB * LIMB;
    localparam bit PAD   = (PW != WIDTH);
    localparam int FI    = PAD ? WIDTH : PW - 1;
    localparam int CW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NLIMB - 1);

    mp_state_e       state_q;
    logic [CW-1:0]   cnt_q;
    logic            carry_q;
    logic            sub_q;
    logic [PW-1:0]   a_q;
    logic [PW-1:0]   b_q;
    logic [PW-1:0]   r_q;
    logic [WIDTH:0]  c_q;
    logic            done_q;

    logic [LIMB-1:0] limb_b;
    logic [LIMB-1:0] limb_sum;
    logic            limb_cout;
    logic [PW-1:0]   r_d;
    logic            flag_d;

    // Current limb operands; B is inverted (padding included) for subtraction.
    always_comb begin
        limb_b = sub_q ? ~b_q[LIMB-1:0] : b_q[LIMB-1:0];
    end

    mp_limb_adder #(
        .LIMB(LIMB)
    ) u_limb (
        .a_i   (a_q[LIMB-1:0]),
        .b_i   (limb_b),
        .cin_i (carry_q),
        .sum_o (limb_sum),
        .cout_o(limb_cout)
    );

    // Shift the new sum limb in from the top; pick the carry/borrow flag.
    always_comb begin
        r_d    = (r_q >> LIMB) | (PW'(limb_sum) << (PW - LIMB));
        flag_d = PAD ? r_d[FI] : (limb_cout ^ sub_q);
    end

    // Sequencer: accept in IDLE, ripple NLIMB limbs in RUN, pulse done in DONE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= PW'(A);
                        b_q     <= PW'(B);
                        sub_q   <= subtract;
                        carry_q <= subtract;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> LIMB;
                    b_q     <= b_q >> LIMB;
                    r_q     <= r_d;
                    carry_q <= limb_cout;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        c_q     <= {flag_d, r_d[WIDTH-1:0]};
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign C    = c_q;
    assign done = done_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mp_addsub_seq.sv
// Self-checking bench for mp_addsub_seq at three parameter points.
// Results are compared against a plain-arithmetic reference model.
module tb_mp_addsub_seq;

    localparam int W0 = 514;
    localparam int L0 = 128;
    localparam int W1 = 1027;
    localparam int L1 = 64;
    localparam int W2 = 8;
    localparam int L2 = 8;
    localparam int NL0 = (W0 + L0 - 1) / L0;
    localparam int NL1 = (W1 + L1 - 1) / L1;
    localparam int NL2 = (W2 + L2 - 1) / L2;

    logic clk;
    logic rstn;

    logic          start0, sub0, done0, busy0;
    logic [W0-1:0] A0, B0;
    logic [W0:0]   C0;
    logic          start1, sub1, done1, busy1;
    logic [W1-1:0] A1, B1;
    logic [W1:0]   C1;
    logic          start2, sub2, done2, busy2;
    logic [W2-1:0] A2, B2;
    logic [W2:0]   C2;

    int total;
    int bad;

    mp_addsub_seq #(.WIDTH(W0), .LIMB(L0)) dut0 (
        .clk(clk), .rstn(rstn), .start(start0), .subtract(sub0),
        .A(A0), .B(B0), .C(C0), .done(done0), .busy(busy0)
    );
    mp_addsub_seq #(.WIDTH(W1), .LIMB(L1)) dut1 (
        .clk(clk), .rstn(rstn), .start(start1), .subtract(sub1),
        .A(A1), .B(B1), .C(C1), .done(done1), .busy(busy1)
    );
    mp_addsub_seq #(.WIDTH(W2), .LIMB(L2)) dut2 (
        .clk(clk), .rstn(rstn), .start(start2), .subtract(sub2),
        .A(A2), .B(B2), .C(C2), .done(done2), .busy(busy2)
    );

    always #5 clk = ~clk;

    // Exact unsigned arithmetic on w-bit operands.
    function automatic logic [1027:0] ref_model(input int w, input logic s,
                                                input logic [1026:0] a,
                                                input logic [1026:0] b);
        logic [1027:0] m, aa, bb, r;
        m  = (1028'(1) << w) - 1028'(1);
        aa = {1'b0, a} & m;
        bb = {1'b0, b} & m;
        if (!s) begin
            r = aa + bb;
        end else begin
            r = (aa - bb) & m;
            if (aa < bb) r[w] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [1026:0] rnd();
        logic [1055:0] t;
        int mode;
        mode = $urandom_range(0, 7);
        for (int i = 0; i < 33; i++) t[i*32 +: 32] = $urandom;
        if (mode == 0) t = '1;
        else if (mode == 1) t = '0;
        else if (mode == 2) t = 1056'($urandom_range(0, 15));
        return t[1026:0];
    endfunction

    function automatic logic busy_of(input int id);
        case (id)
            0: return busy0;
            1: return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic done_of(input int id);
        case (id)
            0: return done0;
            1: return done1;
            default: return done2;
        endcase
    endfunction

    // Waits for idle, launches one op, scrambles inputs, waits for done.
    task automatic do_op(input int id, input logic s,
                         input logic [1026:0] a, input logic [1026:0] b,
                         output logic [1027:0] c, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (busy_of(id) && n < 100) begin
            @(negedge clk);
            n++;
        end
        case (id)
            0: begin start0 = 1; sub0 = s; A0 = a[W0-1:0]; B0 = b[W0-1:0]; end
            1: begin start1 = 1; sub1 = s; A1 = a[W1-1:0]; B1 = b[W1-1:0]; end
            default: begin start2 = 1; sub2 = s; A2 = a[W2-1:0]; B2 = b[W2-1:0]; end
        endcase
        @(posedge clk);
        #1;
        start0 = 0; start1 = 0; start2 = 0;
        A0 = ~A0; B0 = ~B0; sub0 = ~sub0;
        A1 = ~A1; B1 = ~B1; sub1 = ~sub1;
        A2 = ~A2; B2 = ~B2; sub2 = ~sub2;
        lat = 0;
        while (!done_of(id) && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        case (id)
            0: c = 1028'(C0);
            1: c = 1028'(C1);
            default: c = 1028'(C2);
        endcase
    endtask

    task automatic test_reset();
        rstn = 1;
        #3;
        rstn = 0;
        #1;
        total++;
        if (C0 !== '0) begin
            bad++; $display("FAIL reset_C0 got=%h exp=0", C0);
        end
        total++;
        if (done0 !== 1'b0) begin
            bad++; $display("FAIL reset_done got=%b exp=0", done0);
        end
        total++;
        if (busy0 !== 1'b0) begin
            bad++; $display("FAIL reset_busy got=%b exp=0", busy0);
        end
        total++;
        if (C1 !== '0 || C2 !== '0) begin
            bad++; $display("FAIL reset_C12 got=%h/%h exp=0", C1[63:0], C2);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1;
    endtask

    task automatic test_add_overflow();
        logic [1027:0] c, e;
        int lat;
        e = 1028'(1) << 514;
        do_op(0, 0, (1027'(1) << 514) - 1027'(1), 1027'(1), c, lat);
        total++;
        if (c !== e) begin
            bad++; $display("FAIL add_max got=%h exp=%h", c[514:0], e[514:0]);
        end
        total++;
        if (lat !== NL0) begin
            bad++; $display("FAIL add_latency got=%0d exp=%0d", lat, NL0);
        end
        @(posedge clk);
        #1;
        total++;
        if (done0 !== 1'b0) begin
            bad++; $display("FAIL done_width got=%b exp=0", done0);
        end
    endtask

    task automatic test_sub();
        logic [1027:0] c, e;
        logic [1026:0] r;
        int lat;
        e = (1028'(1) << 515) - 1028'(2);
        do_op(0, 1, 1027'(5), 1027'(7), c, lat);
        total++;
        if (c !== e) begin
            bad++; $display("FAIL sub_borrow got=%h exp=%h", c[514:0], e[514:0]);
        end
        r = rnd();
        r[255:0] = {8{32'h1234_5678}};
        do_op(0, 1, r, r, c, lat);
        total++;
        if (c !== '0) begin
            bad++; $display("FAIL sub_equal got=%h exp=0", c[514:0]);
        end
    endtask

    task automatic test_ripple();
        logic [1027:0] c, e;
        int lat;
        e = 1028'(1) << 128;
        do_op(0, 0, (1027'(1) << 128) - 1027'(1), 1027'(1), c, lat);
        total++;
        if (c !== e) begin
            bad++; $display("FAIL ripple_add got=%h exp=%h", c[514:0], e[514:0]);
        end
        e = (1028'(1) << 384) - 1028'(1);
        do_op(0, 1, 1027'(1) << 384, 1027'(1), c, lat);
        total++;
        if (c !== e) begin
            bad++; $display("FAIL ripple_sub got=%h exp=%h", c[514:0], e[514:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [1027:0] c, e;
        logic [1026:0] a, b;
        logic [W0:0] hold;
        int lat;
        longint t1, t2;
        a = rnd(); b = rnd();
        do_op(0, 0, a, b, c, lat);
        t1 = $time;
        e = ref_model(W0, 0, a, b);
        total++;
        if (c !== e) begin
            bad++; $display("FAIL b2b_first got=%h exp=%h", c[514:0], e[514:0]);
        end
        a = rnd(); b = rnd();
        do_op(0, 1, a, b, c, lat);
        t2 = $time;
        e = ref_model(W0, 1, a, b);
        total++;
        if (c !== e) begin
            bad++; $display("FAIL b2b_second got=%h exp=%h", c[514:0], e[514:0]);
        end
        total++;
        if (t2 - t1 != longint'((NL0 + 2) * 10)) begin
            bad++; $display("FAIL b2b_spacing got=%0d exp=%0d", t2 - t1, (NL0 + 2) * 10);
        end
        hold = 515'(e);
        repeat (6) begin
            @(negedge clk);
            A0 = rnd()[W0-1:0];
            B0 = ~A0;
            sub0 = ~sub0;
        end
        total++;
        if (C0 !== hold) begin
            bad++; $display("FAIL idle_hold got=%h exp=%h", C0, hold);
        end
    endtask

    task automatic test_handshake();
        logic e_done, e_busy;
        int n;
        n = 0;
        @(negedge clk);
        while (busy0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        start0 = 1; sub0 = 0; A0 = 514'(1); B0 = 514'(2);
        for (int j = 0; j <= 13; j++) begin
            @(posedge clk);
            #1;
            e_done = (j == 5) || (j == 12);
            e_busy = (j != 6) && (j != 13);
            total++;
            if (done0 !== e_done) begin
                bad++; $display("FAIL hs_done edge=%0d got=%b exp=%b", j, done0, e_done);
            end
            total++;
            if (busy0 !== e_busy) begin
                bad++; $display("FAIL hs_busy edge=%0d got=%b exp=%b", j, busy0, e_busy);
            end
            if (j == 8) start0 = 0;
        end
        total++;
        if (C0 !== 515'(3)) begin
            bad++; $display("FAIL hs_result got=%h exp=3", C0);
        end
    endtask

    task automatic test_reset_mid();
        logic [1027:0] c;
        logic seen;
        int lat;
        @(negedge clk);
        start0 = 1; sub0 = 0; A0 = '1; B0 = '1;
        @(posedge clk);
        #1;
        start0 = 0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rstn = 0;
        #1;
        total++;
        if (C0 !== '0) begin
            bad++; $display("FAIL mid_reset_C got=%h exp=0", C0);
        end
        total++;
        if (done0 !== 1'b0 || busy0 !== 1'b0) begin
            bad++; $display("FAIL mid_reset_ctl got=%b%b exp=00", done0, busy0);
        end
        @(negedge clk);
        rstn = 1;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done0 !== 1'b0 || busy0 !== 1'b0) seen = 1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL mid_reset_spurious got=%b exp=0", seen);
        end
        do_op(0, 0, 1027'(3), 1027'(4), c, lat);
        total++;
        if (c !== 1028'(7)) begin
            bad++; $display("FAIL mid_reset_add got=%h exp=7", c[514:0]);
        end
        total++;
        if (lat !== NL0) begin
            bad++; $display("FAIL mid_reset_latency got=%0d exp=%0d", lat, NL0);
        end
    endtask

    task automatic test_sweep(input int id, input int w, input int nl, input int n);
        logic [1027:0] c, e;
        logic [1026:0] a, b;
        logic s;
        int lat;
        for (int i = 0; i < n; i++) begin
            s = 1'($urandom_range(0, 1));
            a = rnd();
            b = ($urandom_range(0, 9) == 0) ? a : rnd();
            do_op(id, s, a, b, c, lat);
            e = ref_model(w, s, a, b);
            total++;
            if (c !== e) begin
                bad++;
                $display("FAIL sweep%0d op=%0d sub=%b flag got=%b exp=%b lo got=%h exp=%h",
                         id, i, s, c[w], e[w], c[127:0], e[127:0]);
            end
            total++;
            if (lat !== nl) begin
                bad++; $display("FAIL sweep%0d_latency op=%0d got=%0d exp=%0d", id, i, lat, nl);
            end
        end
    endtask

    initial begin
        clk = 0;
        rstn = 1;
        total = 0;
        bad = 0;
        start0 = 0; sub0 = 0; A0 = '0; B0 = '0;
        start1 = 0; sub1 = 0; A1 = '0; B1 = '0;
        start2 = 0; sub2 = 0; A2 = '0; B2 = '0;
        test_reset();
        test_add_overflow();
        test_sub();
        test_ripple();
        test_back_to_back();
        test_handshake();
        test_reset_mid();
        test_sweep(0, W0, NL0, 100);
        test_sweep(1, W1, NL1, 1000);
        test_sweep(2, W2, NL2, 1000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
